// File: rtl/seq_divider_16.sv
// seq_divider_16: iterative unsigned restoring divider.
// Produces one quotient bit per clock. Operands and results move over
// valid/ready handshakes. A zero divisor short-circuits to an all-ones
// quotient with the dividend as remainder, flagged by div_by_zero.
module seq_divider_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                 CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;

    logic [WIDTH-1:0]   q_r;          // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   r_r;          // partial remainder
    logic [WIDTH-1:0]   d_r;          // latched divisor
    logic [CNT_W-1:0]   cnt_r;        // step index within the current division
    logic [WIDTH-1:0]   quotient_r;
    logic [WIDTH-1:0]   remainder_r;
    logic               dbz_r;

    logic [WIDTH:0]     t_s;          // shifted partial remainder, one bit wider
    logic [WIDTH:0]     diff_s;       // trial subtraction; MSB set means borrow
    logic [WIDTH-1:0]   q_next_s;
    logic [WIDTH-1:0]   r_next_s;

    // Handshake flags decode directly from the state register.
    assign in_ready    = (state_r == IDLE);
    assign out_valid   = (state_r == DONE);
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

    // One restoring step: trial-subtract the divisor, keep the result only if no borrow.
    always_comb begin
        t_s    = {r_r, q_r[WIDTH-1]};
        diff_s = t_s - {1'b0, d_r};
        if (diff_s[WIDTH] == 1'b0) begin
            r_next_s = diff_s[WIDTH-1:0];
            q_next_s = {q_r[WIDTH-2:0], 1'b1};
        end else begin
            r_next_s = t_s[WIDTH-1:0];
            q_next_s = {q_r[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state logic for the IDLE -> BUSY -> DONE sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    if (divisor == ZERO_W) begin
                        state_s = DONE;
                    end else begin
                        state_s = BUSY;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r         <= ZERO_W;
            r_r         <= ZERO_W;
            d_r         <= ZERO_W;
            cnt_r       <= {CNT_W{1'b0}};
            quotient_r  <= ZERO_W;
            remainder_r <= ZERO_W;
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        if (divisor == ZERO_W) begin
                            quotient_r  <= ONES_W;
                            remainder_r <= dividend;
                            dbz_r       <= 1'b1;
                        end else begin
                            q_r   <= dividend;
                            r_r   <= ZERO_W;
                            d_r   <= divisor;
                            cnt_r <= {CNT_W{1'b0}};
                        end
                    end
                end
                BUSY: begin
                    q_r   <= q_next_s;
                    r_r   <= r_next_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        quotient_r  <= q_next_s;
                        remainder_r <= r_next_s;
                        dbz_r       <= 1'b0;
                    end
                end
                default: begin
                    // DONE: results held until the consumer takes them.
                    q_r <= q_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_16.sv
// Directed and randomized bench for seq_divider_16 (WIDTH = 16).
module tb_seq_divider_16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_checks;
    int n_fail;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } op_t;

    op_t pend_q[$];
    int  acc_cnt;
    int  res_cnt;

    seq_divider_16 #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One directed division; exp_edge is the edge index (E0 = acceptance) after
    // which out_valid must first be seen. hold > 0 keeps out_ready low that many
    // cycles while the inputs are disturbed.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input logic edz,
                          input int exp_edge, input int hold);
        int k;
        @(negedge clk);
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 16'hA5A5;
        divisor  = 16'h0000;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 40);
        check({tag, "_valid_edge"}, 32'(k - 1), 32'(exp_edge));
        check({tag, "_quotient"}, 32'(quotient), 32'(eq));
        check({tag, "_remainder"}, 32'(remainder), 32'(er));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(edz));
        for (int h = 0; h < hold; h++) begin
            in_valid = ~in_valid;
            dividend = 16'($urandom);
            divisor  = 16'($urandom);
            @(negedge clk);
            check({tag, "_hold_q"}, 32'(quotient), 32'(eq));
            check({tag, "_hold_r"}, 32'(remainder), 32'(er));
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_hold_out_valid"}, 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_consumed_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_consumed_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Random producer: operands held with in_valid until accepted.
    task automatic producer();
        int w;
        op_t op;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            op.a = 16'($urandom);
            case ($urandom_range(0, 9))
                0:       op.b = 16'h0000;
                1, 2:    op.b = 16'($urandom_range(1, 15));
                default: op.b = 16'($urandom);
            endcase
            dividend = op.a;
            divisor  = op.b;
            in_valid = 1'b1;
            w = 0;
            while (!in_ready && w < 100) begin
                @(negedge clk);
                w++;
            end
            check("rand_accept_timeout", 32'(in_ready), 32'd1);
            pend_q.push_back(op);
            acc_cnt++;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    // Random consumer: random backpressure, result checked when consumed.
    task automatic consumer();
        int cyc;
        op_t op;
        logic [31:0] recon;
        cyc = 0;
        while (res_cnt < 200 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                res_cnt++;
                if (pend_q.size() == 0) begin
                    check("rand_result_without_op", 32'd1, 32'd0);
                end else begin
                    op = pend_q.pop_front();
                    if (op.b == 16'h0000) begin
                        check("rand_dz_q", 32'(quotient), 32'h0000FFFF);
                        check("rand_dz_r", 32'(remainder), 32'(op.a));
                        check("rand_dz_flag", 32'(div_by_zero), 32'd1);
                    end else begin
                        recon = 32'(quotient) * 32'(op.b) + 32'(remainder);
                        check("rand_q", 32'(quotient), 32'(op.a / op.b));
                        check("rand_r", 32'(remainder), 32'(op.a % op.b));
                        check("rand_invariant", recon, 32'(op.a));
                        check("rand_r_lt_d", 32'(remainder < op.b), 32'd1);
                        check("rand_dbz", 32'(div_by_zero), 32'd0);
                    end
                end
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        acc_cnt   = 0;
        res_cnt   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 16'h0000;
        divisor   = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;

        run_op("d100_7",   16'd100,   16'd7,    16'd14,    16'd2,      1'b0, 16, 0);
        run_op("dffff_1",  16'hFFFF,  16'h0001, 16'hFFFF,  16'h0000,   1'b0, 16, 0);
        run_op("d5_9",     16'h0005,  16'h0009, 16'h0000,  16'h0005,   1'b0, 16, 0);
        run_op("d1234_0",  16'h1234,  16'h0000, 16'hFFFF,  16'h1234,   1'b1, 0,  0);
        run_op("d1000_3",  16'd1000,  16'd3,    16'd333,   16'd1,      1'b0, 16, 5);

        // Abort mid-division after 8 steps; outputs must clear without a clock edge.
        @(negedge clk);
        dividend = 16'd60000;
        divisor  = 16'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("d50_6",    16'd50,    16'd6,    16'd8,     16'd2,      1'b0, 16, 0);

        fork
            producer();
            consumer();
        join
        check("rand_result_count", 32'(res_cnt), 32'd200);
        check("rand_accept_vs_result", 32'(acc_cnt), 32'(res_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
